tick_timer_scheduler: RTL and testbench

//   Multi-channel timer scheduler built on one shared prescaler (modulo counter).

---
 rtl/tick_timer_scheduler_pkg.sv | 30 +++
 rtl/tick_timer_scheduler_prescaler.sv | 35 +++
 rtl/tick_timer_scheduler.sv | 123 ++++++++++++
 tb/tb_tick_timer_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_timer_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_timer_pkg
// Purpose  : Shared types for the tick timer scheduler: channel state, command
//            opcodes and the width-independent part of the channel record.
// Revision : 1.0 - initial release
// ============================================================================
package tick_timer_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_START = 2'd1,
    OP_STOP  = 2'd2,
    OP_CLR   = 2'd3
  } cmd_op_e;

  // Control half of a channel record; the counter/period half depends on
  // PERIOD_W and is completed inside the top module.
  typedef struct packed {
    ch_state_e state;
    logic      periodic;
  } ch_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/tick_timer_scheduler_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Modulo-PRESCALE counter producing the shared base tick.
// Ports    : clk, reset (async, active-low)
//            i_enable - advance the counter; low freezes it
//            o_tick   - combinational, high on the last count while enabled
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int PRESCALE = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int            c_W    = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);
  localparam logic [c_W-1:0] c_LAST = c_W'(PRESCALE - 1);

  logic [c_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_W'(1);
    end
  end

  assign o_tick = i_enable && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/tick_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tick_timer_scheduler
// Purpose  : NUM_CH independent tick timers sharing one prescaler, driven by a
//            single command port (START / STOP / CLEAR_IRQ).
// Ports    : clk, reset (async, active-low)
//            i_enable        - global run; low freezes prescaler and counters
//            i_cmd_valid/op/ch/period/periodic - command port
//            o_tick          - base tick (combinational)
//            o_busy          - channel running
//            o_expire        - registered one-cycle expiry pulse
//            o_irq_pending   - sticky expiry flag
// Revision : 1.0 - initial release
// ============================================================================
module tick_timer_scheduler
  import tick_timer_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 5,
  parameter int PERIOD_W = 8,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enable,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd_op,
  input  logic [CH_W-1:0]     i_cmd_ch,
  input  logic [PERIOD_W-1:0] i_cmd_period,
  input  logic                i_cmd_periodic,
  output logic                o_tick,
  output logic [NUM_CH-1:0]   o_busy,
  output logic [NUM_CH-1:0]   o_expire,
  output logic [NUM_CH-1:0]   o_irq_pending
);

  typedef struct packed {
    ch_ctrl_t            ctrl;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] period;
  } ch_regs_t;

  logic    w_tick;
  cmd_op_e w_op;

  assign w_op   = cmd_op_e'(i_cmd_op);
  assign o_tick = w_tick;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .i_enable (i_enable),
    .o_tick   (w_tick)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_regs_t r_ch;
    logic     r_expire;
    logic     r_irq;
    logic     w_sel;
    logic     w_start;
    logic     w_stop;
    logic     w_clr;
    logic     w_last;
    logic     w_fire;

    // Out-of-range channel numbers never match any g, so they are no-ops.
    assign w_sel   = i_cmd_valid && (i_cmd_ch == CH_W'(g));
    assign w_start = w_sel && (w_op == OP_START) && (i_cmd_period != '0);
    assign w_stop  = w_sel && (w_op == OP_STOP);
    assign w_clr   = w_sel && (w_op == OP_CLR);
    assign w_last  = (r_ch.ctrl.state == CH_RUN) && w_tick &&
                     (r_ch.cnt <= PERIOD_W'(1));
    // START and STOP both pre-empt an expiry landing in the same cycle.
    assign w_fire  = w_last && !w_start && !w_stop;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_ch     <= '0;
        r_expire <= 1'b0;
        r_irq    <= 1'b0;
      end else begin
        r_expire <= w_fire;

        // Expiry setting the flag beats a coincident CLEAR_IRQ.
        if (w_fire) begin
          r_irq <= 1'b1;
        end else if (w_clr) begin
          r_irq <= 1'b0;
        end

        if (w_start) begin
          r_ch.ctrl.state    <= CH_RUN;
          r_ch.ctrl.periodic <= i_cmd_periodic;
          r_ch.cnt           <= i_cmd_period;
          r_ch.period        <= i_cmd_period;
        end else if (w_stop) begin
          r_ch.ctrl.state <= CH_IDLE;
          r_ch.cnt        <= '0;
        end else if ((r_ch.ctrl.state == CH_RUN) && w_tick) begin
          if (w_last) begin
            if (r_ch.ctrl.periodic) begin
              r_ch.cnt <= r_ch.period;
            end else begin
              r_ch.ctrl.state <= CH_IDLE;
              r_ch.cnt        <= '0;
            end
          end else begin
            r_ch.cnt <= r_ch.cnt - PERIOD_W'(1);
          end
        end
      end
    end

    assign o_busy[g]        = (r_ch.ctrl.state == CH_RUN);
    assign o_expire[g]      = r_expire;
    assign o_irq_pending[g] = r_irq;
  end

endmodule
`default_nettype wire

// File: tb/tb_tick_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_timer_scheduler
// Purpose  : Self-checking bench for tick_timer_scheduler: table vectors,
//            directed corner sequences and randomized traffic against a
//            remaining-ticks reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_timer_scheduler;

  localparam int NUM_CH   = 4;
  localparam int PRESCALE = 5;
  localparam int PERIOD_W = 8;
  localparam int CH_W     = 2;

  localparam logic [1:0] NOP = 2'd0, START = 2'd1, STOP = 2'd2, CLR = 2'd3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                en = 1'b0;
  logic                valid = 1'b0;
  logic [1:0]          op = 2'd0;
  logic [CH_W-1:0]     ch = '0;
  logic [PERIOD_W-1:0] per = '0;
  logic                pdc = 1'b0;
  logic                tick;
  logic [NUM_CH-1:0]   busy, expire, irq;

  always #5 clk = ~clk;

  tick_timer_scheduler #(
    .NUM_CH(NUM_CH), .PRESCALE(PRESCALE), .PERIOD_W(PERIOD_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .reset(reset), .i_enable(en), .i_cmd_valid(valid),
    .i_cmd_op(op), .i_cmd_ch(ch), .i_cmd_period(per), .i_cmd_periodic(pdc),
    .o_tick(tick), .o_busy(busy), .o_expire(expire), .o_irq_pending(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is "running with N ticks left".
  int m_en_cycles;
  bit m_run [NUM_CH];
  int m_left[NUM_CH];
  int m_per [NUM_CH];
  bit m_pdc [NUM_CH];
  bit m_irq [NUM_CH];
  bit m_exp [NUM_CH];

  function automatic void m_reset();
    m_en_cycles = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_left[c] = 0; m_per[c] = 0; m_pdc[c] = 0; m_irq[c] = 0; m_exp[c] = 0;
    end
  endfunction

  function automatic bit m_tick(input bit e);
    return e && ((m_en_cycles % PRESCALE) == PRESCALE - 1);
  endfunction

  function automatic void m_step(input bit e, input bit v, input int o, input int c_sel,
                                 input int p, input bit pd);
    bit t;
    t = m_tick(e);
    if (e) m_en_cycles++;
    for (int c = 0; c < NUM_CH; c++) begin
      bit hit, fired;
      hit   = v && (c_sel == c);
      fired = 0;
      m_exp[c] = 0;
      if (hit && o == 1 && p != 0) begin
        m_run[c] = 1; m_left[c] = p; m_per[c] = p; m_pdc[c] = pd;
      end else if (hit && o == 2) begin
        m_run[c] = 0; m_left[c] = 0;
      end else if (m_run[c] && t) begin
        m_left[c] = m_left[c] - 1;
        if (m_left[c] == 0) begin
          fired = 1;
          if (m_pdc[c]) m_left[c] = m_per[c];
          else m_run[c] = 0;
        end
      end
      if (fired) begin
        m_exp[c] = 1; m_irq[c] = 1;
      end else if (hit && o == 3) begin
        m_irq[c] = 0;
      end
    end
  endfunction

  function automatic logic [NUM_CH-1:0] pack(input bit a [NUM_CH]);
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = a[c];
    return r;
  endfunction

  // One clock: called just after a rising edge; drives, checks tick, clocks,
  // then checks registered outputs against the model.
  task automatic cycle(input bit e, input bit v, input logic [1:0] o,
                       input logic [CH_W-1:0] c, input logic [PERIOD_W-1:0] p, input bit pd);
    en = e; valid = v; op = o; ch = c; per = p; pdc = pd;
    #1;
    chk("tick", {31'd0, tick}, {31'd0, m_tick(e)});
    @(posedge clk);
    m_step(e, v, int'(o), int'(c), int'(p), pd);
    #1;
    chk("busy",   32'(busy),   32'(pack(m_run)));
    chk("expire", 32'(expire), 32'(pack(m_exp)));
    chk("irq",    32'(irq),    32'(pack(m_irq)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, NOP, 0, 0, 0);
  endtask

  // Idle until the model says the coming cycle carries a tick, then issue
  // the given command in that cycle.
  task automatic cmd_on_tick(input string name, input logic [1:0] o, input logic [CH_W-1:0] c,
                             input logic [PERIOD_W-1:0] p, input bit pd);
    bit done;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (m_tick(1)) begin
        cycle(1, 1, o, c, p, pd);
        done = 1;
      end else begin
        cycle(1, 0, NOP, 0, 0, 0);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s: no tick within 20 cycles (got none, required one)", name);
    end
  endtask

  // Cycles from the START edge until expire[3] is seen; gap inserts 7 disabled cycles.
  task automatic latency(input bit gap, output int lat);
    cmd_on_tick("lat_start", START, 3, 2, 0);
    lat = 0;
    while (!expire[3] && lat < 60) begin
      if (gap && lat >= 2 && lat < 9) cycle(0, (lat == 4), CLR, 0, 0, 0);
      else cycle(1, 0, NOP, 0, 0, 0);
      lat++;
    end
  endtask

  typedef struct {
    logic              v;
    logic [1:0]        o;
    logic [CH_W-1:0]   c;
    logic [PERIOD_W-1:0] p;
    logic              pd;
    int                idle_n;
    logic [NUM_CH-1:0] exp_busy;
    logic [NUM_CH-1:0] exp_irq;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat;
    bit any_exp;

    vecs[0] = '{1, START, 0, 3, 0, 16, 4'b0000, 4'b0001};
    vecs[1] = '{1, START, 1, 2, 1,  9, 4'b0010, 4'b0011};
    vecs[2] = '{1, CLR,   1, 0, 0,  0, 4'b0010, 4'b0001};
    vecs[3] = '{1, NOP,   0, 0, 0,  7, 4'b0010, 4'b0011};
    vecs[4] = '{1, START, 3, 0, 1,  0, 4'b0010, 4'b0011};
    vecs[5] = '{1, STOP,  1, 0, 0,  0, 4'b0000, 4'b0011};
    vecs[6] = '{1, CLR,   0, 0, 0,  0, 4'b0000, 4'b0010};
    vecs[7] = '{1, CLR,   1, 0, 0,  0, 4'b0000, 4'b0000};
    vecs[8] = '{0, START, 2, 4, 0,  3, 4'b0000, 4'b0000};

    // Reset state
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tick",   {31'd0, tick}, 32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_expire", 32'(expire), 32'd0);
    chk("rst_irq",    32'(irq),    32'd0);
    #2 reset = 1'b1;

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      cycle(1, vecs[i].v, vecs[i].o, vecs[i].c, vecs[i].p, vecs[i].pd);
      idle(vecs[i].idle_n);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_irq", i),  32'(irq),  32'(vecs[i].exp_irq));
    end

    // STOP coincident with the expiry tick
    cycle(1, 1, START, 2, 1, 0);
    cmd_on_tick("stop_vs_exp", STOP, 2, 0, 0);
    chk("stop_vs_exp_expire", {31'd0, expire[2]}, 32'd0);
    chk("stop_vs_exp_irq",    {31'd0, irq[2]},    32'd0);
    chk("stop_vs_exp_busy",   {31'd0, busy[2]},   32'd0);

    // CLEAR_IRQ coincident with expiry
    cycle(1, 1, START, 0, 1, 0);
    cmd_on_tick("clr_vs_exp", CLR, 0, 0, 0);
    chk("clr_vs_exp_expire", {31'd0, expire[0]}, 32'd1);
    chk("clr_vs_exp_irq",    {31'd0, irq[0]},    32'd1);

    // START coincident with expiry: restart wins
    cycle(1, 1, START, 1, 1, 1);
    cmd_on_tick("start_vs_exp", START, 1, 3, 0);
    chk("start_vs_exp_expire", {31'd0, expire[1]}, 32'd0);
    chk("start_vs_exp_busy",   {31'd0, busy[1]},   32'd1);
    idle(16);

    // Enable gap of 7 cycles delays expiry by exactly 7 clocks
    latency(0, lat);
    chk("latency_nogap", 32'(lat), 32'd10);
    latency(1, lat);
    chk("latency_gap", 32'(lat), 32'd17);

    // Asynchronous reset mid-count with three channels running
    cycle(1, 1, START, 0, 4, 1);
    cycle(1, 1, START, 1, 3, 1);
    cycle(1, 1, START, 2, 5, 1);
    idle(3);
    en = 1; valid = 0; op = NOP;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy",   32'(busy),   32'd0);
    chk("async_rst_expire", 32'(expire), 32'd0);
    chk("async_rst_irq",    32'(irq),    32'd0);
    chk("async_rst_tick",   {31'd0, tick}, 32'd0);
    m_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    any_exp = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, NOP, 0, 0, 0);
      any_exp |= |expire;
    end
    chk("post_rst_no_expire", {31'd0, any_exp}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), CH_W'($urandom_range(0, NUM_CH - 1)),
            PERIOD_W'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
